// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux slice: selection-mode encodings and FSM states.
package stream_mux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_ARB  = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority picker: the first requester at or after ptr wins.
// A constant zero ptr turns it into a lowest-index-wins priority encoder.
module rr_arbiter #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] request,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_any
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest offset down so the nearest requester overwrites the result.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (request[idx]) begin
        grant_idx = idx;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-way valid/ready stream multiplexer with packet locking and a one-deep output register.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise lowest index wins.
//
// state     | meaning
// ST_IDLE   | grant recomputed every cycle from address (mode 0) or arbiter (mode 1)
// ST_LOCKED | mid-packet; grant frozen to the latched channel until its last beat
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          address,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_channel
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             addr_ok;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .request   (in_valid),
    .ptr       (rr_ptr),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // With a power-of-two channel count every address value is a real channel.
  generate
    if ((1 << SEL_W) == CHANNELS) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (address < SEL_W'(CHANNELS));
    end
  endgenerate

  assign can_load = !out_valid || out_ready;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state == ST_LOCKED) begin
      grant       = lock_ch;
      grant_valid = 1'b1;
    end else if (mode == MODE_ADDR) begin
      grant       = address;
      grant_valid = addr_ok;
    end else begin
      grant       = arb_idx;
      grant_valid = arb_any;
    end
  end

  always_comb begin
    in_ready = '0;
    if (!reset && can_load && grant_valid)
      in_ready = CHANNELS'(1) << grant;
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      case (state)
        ST_IDLE:   if (!sel_last) state_nxt = ST_LOCKED;
        ST_LOCKED: if (sel_last)  state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      lock_ch     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && state == ST_IDLE)
        lock_ch <= grant;
      if (xfer) begin
        out_valid   <= 1'b1;
        out_data    <= sel_data;
        out_last    <= sel_last;
        out_channel <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_RR_EN
  logic lock_mode;
  logic pkt_mode;

  // A locked packet keeps the mode it started in, so a mid-packet mode flip cannot move the pointer.
  assign pkt_mode = (state == ST_IDLE) ? mode : lock_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      lock_mode <= MODE_ADDR;
    end else begin
      if (xfer && state == ST_IDLE)
        lock_mode <= mode;
      if (xfer && sel_last && pkt_mode == MODE_ARB)
        rr_ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

endmodule
